// File: rtl/pokey_audio_channel_if.sv
// Register-write bus for one POKEY audio channel: AUDF/AUDC write strobes,
// shared write data and the STIMER counter-reload strobe.
interface pokey_audio_channel_if;
  logic       audf_wr;
  logic       audc_wr;
  logic [7:0] din;
  logic       stimer;

  modport master (output audf_wr, output audc_wr, output din, output stimer);
  modport slave  (input  audf_wr, input  audc_wr, input  din, input  stimer);
endinterface

// File: rtl/pokey_audio_channel.sv
// One POKEY audio channel: AUDF+1 tick divider, poly-stream distortion gating,
// optional high-pass flip-flop and a registered volume stage for the mixer.
module pokey_audio_channel #(
  parameter int VOL_W = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  ce,
  input  logic                  base_tick,
  pokey_audio_channel_if.slave  bus,
  input  logic                  poly4_bit,
  input  logic                  poly5_bit,
  input  logic                  poly17_bit,
  input  logic                  hp_enable,
  input  logic                  hp_clock,
  output logic                  timer_pulse,
  output logic                  chan_bit,
  output logic [VOL_W-1:0]      volume_out
);

  logic [7:0]       r_audf;
  logic [7:0]       r_audc;
  logic [7:0]       r_counter;
  logic             r_chan_ff;
  logic             r_hp_ff;
  logic             r_timer_pulse;
  logic [VOL_W-1:0] r_volume;

  logic             w_expire;
  logic             w_gate;
  logic             w_chan_ff_next;
  logic             w_chan_bit;

  // STIMER wins over base_tick, so a simultaneous reload never expires.
  assign w_expire = ce & base_tick & ~bus.stimer & (r_counter == 8'd0);
  assign w_gate   = r_audc[7] | poly5_bit;

  always_comb begin
    w_chan_ff_next = r_chan_ff;
    if (w_expire && w_gate) begin
      if (r_audc[5])
        w_chan_ff_next = ~r_chan_ff;
      else
        w_chan_ff_next = r_audc[6] ? poly4_bit : poly17_bit;
    end
  end

  assign w_chan_bit = hp_enable ? (r_chan_ff ^ r_hp_ff) : r_chan_ff;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_audf <= 8'd0;
      r_audc <= 8'd0;
    end else if (ce) begin
      if (bus.audf_wr) r_audf <= bus.din;
      if (bus.audc_wr) r_audc <= bus.din;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_counter <= 8'd0;
    end else if (ce) begin
      if (bus.stimer || w_expire)
        r_counter <= r_audf;
      else if (base_tick)
        r_counter <= r_counter - 8'd1;
    end
  end

  // The pulse is cleared on any edge with ce low, not merely held.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_timer_pulse <= 1'b0;
    else          r_timer_pulse <= w_expire;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_chan_ff <= 1'b0;
      r_hp_ff   <= 1'b0;
    end else if (ce) begin
      r_chan_ff <= w_chan_ff_next;
      if (!hp_enable)
        r_hp_ff <= 1'b0;
      else if (hp_clock)
        r_hp_ff <= r_chan_ff;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_volume <= '0;
    end else if (ce) begin
      if (r_audc[4] || w_chan_bit)
        r_volume <= VOL_W'(r_audc[3:0]);
      else
        r_volume <= '0;
    end
  end

  assign timer_pulse = r_timer_pulse;
  assign chan_bit    = w_chan_bit;
  assign volume_out  = r_volume;

endmodule
